// File: rtl/mag_com_seq_if.sv
// mag_com_seq_if -- job handshake and result bus for mag_com_seq.
//
// Parameter:
//   W      operand width in bits (multiple of 4, >= 4)
// Signals:
//   start  job request, sampled by the controller only while busy=0
//   A, B   operands, captured on the accepting edge
//   busy   high while a job is in progress
//   done   one-cycle pulse when E/G/L have just been updated
//   E/G/L  registered result: A == B / A > B / A < B
// Modports:
//   master  requester side (drives start/A/B)
//   slave   controller side (drives busy/done/E/G/L)
interface mag_com_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         E;
  logic         G;
  logic         L;

  modport master (
    output start, A, B,
    input  busy, done, E, G, L
  );

  modport slave (
    input  start, A, B,
    output busy, done, E, G, L
  );
endinterface

// File: rtl/mag_com_seq.sv
// mag_com_seq -- sequential W-bit unsigned magnitude comparator.
//
// A single 4-bit comparator slice (mag_com_4bit) is stepped across the
// captured operands one nibble per clock, most-significant nibble first.
// The first unequal nibble decides the result; later nibbles cannot
// override it.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (aborts any job in flight)
//   bus   mag_com_seq_if.slave: start/A/B in, busy/done/E/G/L out
//
// Build option:
//   MAG_SEQ_EARLY_EXIT_EN  when defined, a job ends on the first unequal
//                          nibble (latency 1..NIB); otherwise every job
//                          scans all NIB nibbles (latency fixed at NIB).
//                          The result is the same either way.

// 4-bit unsigned comparator slice.
module mag_com_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       E,
  output logic       G,
  output logic       L
);
  assign E = (A == B);
  assign G = (A >  B);
  assign L = (A <  B);
endmodule

module mag_com_seq #(
  parameter int W = 16
) (
  input logic         clk,
  input logic         rst,
  mag_com_seq_if.slave bus
);
  localparam int NIB  = W / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NIB - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IDXW-1:0] idx;
  logic            dec_g;   // sticky: an earlier nibble found A > B
  logic            dec_l;   // sticky: an earlier nibble found A < B
  logic            busy_q;
  logic            done_q;
  logic            e_q;
  logic            g_q;
  logic            l_q;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic            nib_e;
  logic            nib_g;
  logic            nib_l;
  logic            decided;
  logic            fin_e;
  logic            fin_g;
  logic            fin_l;
  logic            last;

  // Nibble select feeding the single comparator slice.
  always_comb begin
    a_nib = a_q[4*int'(idx) +: 4];
    b_nib = b_q[4*int'(idx) +: 4];
  end

  mag_com_4bit u_slice (
    .A (a_nib),
    .B (b_nib),
    .E (nib_e),
    .G (nib_g),
    .L (nib_l)
  );

  // Decision after including the current nibble. Once an earlier nibble has
  // decided, the current slice result is ignored; E survives only if no
  // nibble so far has differed.
  always_comb begin
    decided = dec_g | dec_l;
    fin_g   = dec_g | (~decided & nib_g);
    fin_l   = dec_l | (~decided & nib_l);
    fin_e   = ~decided & nib_e;
`ifdef MAG_SEQ_EARLY_EXIT_EN
    last    = (idx == '0) | fin_g | fin_l;
`else
    last    = (idx == '0);
`endif
  end

  // Operand capture. These registers are only read in CMP, which is always
  // entered through a capture, so they carry no reset.
  // NOTE: datapath-only registers are left unreset; resetting them would add
  // fan-out on rst without changing any observable behaviour.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_q <= bus.A;
      b_q <= bus.B;
    end
  end

  // Control FSM with registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      dec_g  <= 1'b0;
      dec_l  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      e_q    <= 1'b0;
      g_q    <= 1'b0;
      l_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx    <= IDX_TOP;
            dec_g  <= 1'b0;
            dec_l  <= 1'b0;
            busy_q <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          if (last) begin
            e_q    <= fin_e;
            g_q    <= fin_g;
            l_q    <= fin_l;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx   <= idx - 1'b1;
            dec_g <= fin_g;
            dec_l <= fin_l;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.E    = e_q;
  assign bus.G    = g_q;
  assign bus.L    = l_q;
endmodule

// File: tb/tb_mag_com_seq.sv
// tb_mag_com_seq -- self-checking bench for mag_com_seq (W=16).
// Directed scenarios (reset abort, equal, MSB/LSB decides, busy collision,
// back-to-back) followed by randomized jobs, all checked against a
// reference model built from plain arithmetic on the operands.
// Honours MAG_SEQ_EARLY_EXIT_EN for the expected latency.
module tb_mag_com_seq;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic rst;

  mag_com_seq_if #(.W(W)) bus ();

  mag_com_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the last reported result (held between completions).
  logic prev_e = 1'b0;
  logic prev_g = 1'b0;
  logic prev_l = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Expected done edge after acceptance.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAG_SEQ_EARLY_EXIT_EN
    int k = 1;
    for (int i = NIB - 1; i > 0; i--) begin
      if ((int'(a) >> (4 * i)) % 16 != (int'(b) >> (4 * i)) % 16) return k;
      k++;
    end
    return NIB;
`else
    return NIB;
`endif
  endfunction

  // Present a job and step through the accepting edge (edge 0).
  task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit immediate);
    if (!immediate) @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    check("acc_busy", 32'(bus.busy), 32'd1);
    check("acc_done", 32'(bus.done), 32'd0);
    check("hold_egl", {29'd0, bus.E, bus.G, bus.L}, {29'd0, prev_e, prev_g, prev_l});
  endtask

  // Wait (bounded) for done, starting at edge k0; check latency and result.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int k0);
    int k = k0;
    while (bus.done !== 1'b1 && k < NIB + 4) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, exp_lat(a, b));
    check("done_busy", 32'(bus.busy), 32'd0);
    prev_e = (a == b);
    prev_g = (a >  b);
    prev_l = (a <  b);
    check("result", {29'd0, bus.E, bus.G, bus.L}, {29'd0, prev_e, prev_g, prev_l});
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      check(tag, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           mode;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_egl", {29'd0, bus.E, bus.G, bus.L}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-job aborts it: no done pulse, outputs cleared at once.
    start_job(16'h1234, 16'h1235, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_egl", {29'd0, bus.E, bus.G, bus.L}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("abort_no_done", NIB + 2);

    // Equal operands.
    start_job(16'h1234, 16'h1234, 1'b0);
    wait_done(16'h1234, 16'h1234, 0);

    // MSB nibble decides.
    start_job(16'hC000, 16'hB0FF, 1'b0);
    wait_done(16'hC000, 16'hB0FF, 0);

    // LSB nibble decides.
    start_job(16'h4564, 16'h4565, 1'b0);
    wait_done(16'h4564, 16'h4565, 0);

    // Start pulsed at edge 2 of a running job is ignored.
    start_job(16'h4564, 16'h4565, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    bus.A     = 16'h0000;
    bus.B     = 16'hFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(16'h4564, 16'h4565, 2);
    expect_quiet("collide_no_done", NIB + 2);

    // Back-to-back: start held during the done cycle.
    start_job(16'h00E0, 16'h00D0, 1'b0);
    wait_done(16'h00E0, 16'h00D0, 0);
    start_job(16'h0001, 16'h0002, 1'b1);
    wait_done(16'h0001, 16'h0002, 0);

    // Randomized jobs: random, equal, and single-nibble-different operands.
    for (int n = 0; n < 30; n++) begin
      a    = W'($urandom);
      mode = int'($urandom_range(0, 2));
      case (mode)
        0:       b = W'($urandom);
        1:       b = a;
        default: b = a ^ W'($urandom_range(1, 15) << (4 * $urandom_range(0, NIB - 1)));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        start_job(a, b, 1'b1);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_job(a, b, 1'b0);
      end
      wait_done(a, b, 0);
    end

    expect_quiet("tail_no_done", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
